// File: rtl/module_codificador_hamming_pkg.sv
// pkg_hamming: shared Hamming(8,4) bit positions, injection modes, FSM states and syndrome helper
// Codeword layout: [p1,p2,d1,p3,d2,d3,d4,p0] at bits 0..7.
package pkg_hamming;
    localparam int unsigned POS_P1 = 0;
    localparam int unsigned POS_P2 = 1;
    localparam int unsigned POS_D1 = 2;
    localparam int unsigned POS_P3 = 3;
    localparam int unsigned POS_D2 = 4;
    localparam int unsigned POS_D3 = 5;
    localparam int unsigned POS_D4 = 6;
    localparam int unsigned POS_P0 = 7;

    typedef enum logic [1:0] {
        MODO_NINGUNO   = 2'b00,
        MODO_SIMPLE    = 2'b01,
        MODO_DOBLE     = 2'b10,
        MODO_RESERVADO = 2'b11
    } modo_t;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    // Returns {paridad_global, s3, s2, s1}; the syndrome is the 1-based Hamming position of a single error.
    function automatic logic [3:0] sindrome_hamming(input logic [7:0] w);
        logic s1, s2, s3;
        s1 = w[POS_P1] ^ w[POS_D1] ^ w[POS_D2] ^ w[POS_D4];
        s2 = w[POS_P2] ^ w[POS_D1] ^ w[POS_D3] ^ w[POS_D4];
        s3 = w[POS_P3] ^ w[POS_D2] ^ w[POS_D3] ^ w[POS_D4];
        return {^w, s3, s2, s1};
    endfunction
endpackage

// File: rtl/module_codificador_hamming_encode.sv
// module_hamming_encode: combinational Hamming(8,4) encoder with overall even parity
// Ports: i_datos [3:0] = {d4,d3,d2,d1}; o_palabra [7:0] = codeword [p1,p2,d1,p3,d2,d3,d4,p0].
module module_hamming_encode
    import pkg_hamming::*;
(
    input  logic [3:0] i_datos,
    output logic [7:0] o_palabra
);
    logic [7:0] w_base;

    always_comb begin
        w_base         = '0;
        w_base[POS_D1] = i_datos[0];
        w_base[POS_D2] = i_datos[1];
        w_base[POS_D3] = i_datos[2];
        w_base[POS_D4] = i_datos[3];
        w_base[POS_P1] = i_datos[0] ^ i_datos[1] ^ i_datos[3];
        w_base[POS_P2] = i_datos[0] ^ i_datos[2] ^ i_datos[3];
        w_base[POS_P3] = i_datos[1] ^ i_datos[2] ^ i_datos[3];
    end

    // w_base has p0 cleared, so its reduction XOR is the parity of bits 0..6.
    assign o_palabra = w_base | ({7'b0, ^w_base} << POS_P0);
endmodule

// File: rtl/module_codificador_hamming.sv
// module_codificador_hamming: handshaked Hamming(8,4) encoder with error injection and delivery counter
// Ports: clk, rst (async active-high); datos_in/valido_in/listo_in input handshake;
//        modo_inyeccion, pos_a, pos_b injection control sampled on accept;
//        palabra_out/valido_out/listo_out output handshake; palabras_enviadas delivery count;
//        error_inyectado marks a held word carrying an injected error.
module module_codificador_hamming
    import pkg_hamming::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  datos_in,
    input  logic        valido_in,
    output logic        listo_in,
    input  logic [1:0]  modo_inyeccion,
    input  logic [2:0]  pos_a,
    input  logic [2:0]  pos_b,
    output logic [7:0]  palabra_out,
    output logic        valido_out,
    input  logic        listo_out,
    output logic [15:0] palabras_enviadas,
    output logic        error_inyectado
);
    estado_t     r_estado;
    logic        r_valido;
    logic [7:0]  r_palabra;
    logic        r_error;
    logic [15:0] r_cuenta;

    logic [7:0]  w_codigo;
    logic [7:0]  w_mascara;
    logic        w_error;
    logic        w_in_xfer;
    logic        w_out_xfer;

    module_hamming_encode u_encode (
        .i_datos   (datos_in),
        .o_palabra (w_codigo)
    );

    // OR-ing the two one-hot masks makes pos_a==pos_b flip that bit once.
    assign w_mascara = (modo_inyeccion == MODO_SIMPLE) ? (8'b1 << pos_a) :
                       (modo_inyeccion == MODO_DOBLE)  ? ((8'b1 << pos_a) | (8'b1 << pos_b)) : 8'b0;
    assign w_error    = (modo_inyeccion == MODO_SIMPLE) || (modo_inyeccion == MODO_DOBLE);

    assign listo_in   = (r_estado == VACIO) || listo_out;
    assign w_in_xfer  = valido_in && listo_in;
    assign w_out_xfer = r_valido && listo_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= VACIO;
            r_valido  <= 1'b0;
            r_palabra <= 8'h00;
            r_error   <= 1'b0;
            r_cuenta  <= 16'h0000;
        end else begin
            if (w_out_xfer)
                r_cuenta <= r_cuenta + 16'd1;
            // An accept always leaves a word held; otherwise a delivered word empties the stage.
            if (w_in_xfer) begin
                r_estado  <= LLENO;
                r_valido  <= 1'b1;
                r_palabra <= w_codigo ^ w_mascara;
                r_error   <= w_error;
            end else if (w_out_xfer) begin
                r_estado  <= VACIO;
                r_valido  <= 1'b0;
            end
        end
    end

    assign palabra_out       = r_palabra;
    assign valido_out        = r_valido;
    assign error_inyectado   = r_error;
    assign palabras_enviadas = r_cuenta;
endmodule

// File: tb/tb_module_codificador_hamming.sv
// tb_module_codificador_hamming: directed table-driven bench for the Hamming encoder
module tb_module_codificador_hamming;
    import pkg_hamming::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  datos_in = '0;
    logic        valido_in = 1'b0;
    logic        listo_in;
    logic [1:0]  modo_inyeccion = 2'b00;
    logic [2:0]  pos_a = '0;
    logic [2:0]  pos_b = '0;
    logic [7:0]  palabra_out;
    logic        valido_out;
    logic        listo_out = 1'b1;
    logic [15:0] palabras_enviadas;
    logic        error_inyectado;

    int n_cmp = 0;
    int n_err = 0;

    module_codificador_hamming dut (
        .clk               (clk),
        .rst               (rst),
        .datos_in          (datos_in),
        .valido_in         (valido_in),
        .listo_in          (listo_in),
        .modo_inyeccion    (modo_inyeccion),
        .pos_a             (pos_a),
        .pos_b             (pos_b),
        .palabra_out       (palabra_out),
        .valido_out        (valido_out),
        .listo_out         (listo_out),
        .palabras_enviadas (palabras_enviadas),
        .error_inyectado   (error_inyectado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] datos;
        logic [1:0] modo;
        logic [2:0] pa;
        logic [2:0] pb;
        logic [7:0] exp_palabra;
        logic       exp_err;
        logic [3:0] exp_sin;
    } vec_t;

    vec_t tabla [9];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tabla[0] = '{4'hB, 2'b00, 3'd0, 3'd0, 8'h55, 1'b0, 4'b0000};
        tabla[1] = '{4'h0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 4'b0000};
        tabla[2] = '{4'hF, 2'b00, 3'd0, 3'd0, 8'hFF, 1'b0, 4'b0000};
        tabla[3] = '{4'hB, 2'b01, 3'd2, 3'd0, 8'h51, 1'b1, 4'b1011};
        tabla[4] = '{4'h0, 2'b10, 3'd0, 3'd7, 8'h81, 1'b1, 4'b0001};
        tabla[5] = '{4'h0, 2'b10, 3'd3, 3'd3, 8'h08, 1'b1, 4'b1100};
        tabla[6] = '{4'hB, 2'b11, 3'd2, 3'd5, 8'h55, 1'b0, 4'b0000};
        tabla[7] = '{4'h5, 2'b00, 3'd0, 3'd0, 8'h2D, 1'b0, 4'b0000};
        tabla[8] = '{4'h6, 2'b01, 3'd7, 3'd0, 8'hB3, 1'b1, 4'b1000};

        #2;
        chk("reset_valido", valido_out, 1'b0);
        chk("reset_palabra", palabra_out, 8'h00);
        chk("reset_error", error_inyectado, 1'b0);
        chk("reset_cuenta", palabras_enviadas, 16'h0000);
        chk("reset_listo_in", listo_in, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        listo_out = 1'b1;
        for (int i = 0; i < 9; i++) begin
            datos_in       = tabla[i].datos;
            modo_inyeccion = tabla[i].modo;
            pos_a          = tabla[i].pa;
            pos_b          = tabla[i].pb;
            valido_in      = 1'b1;
            step();
            chk($sformatf("tabla%0d_palabra", i), palabra_out, tabla[i].exp_palabra);
            chk($sformatf("tabla%0d_error", i), error_inyectado, tabla[i].exp_err);
            chk($sformatf("tabla%0d_valido", i), valido_out, 1'b1);
            chk($sformatf("tabla%0d_sindrome", i), sindrome_hamming(palabra_out), tabla[i].exp_sin);
        end
        chk("tabla_cuenta", palabras_enviadas, 16'd8);
        valido_in = 1'b0;
        step();
        chk("vaciado_valido", valido_out, 1'b0);
        chk("vaciado_cuenta", palabras_enviadas, 16'd9);
        chk("vaciado_listo_in", listo_in, 1'b1);

        listo_out      = 1'b0;
        datos_in       = 4'hB;
        modo_inyeccion = 2'b01;
        pos_a          = 3'd0;
        valido_in      = 1'b1;
        step();
        chk("bp_acepta_palabra", palabra_out, 8'h54);
        chk("bp_acepta_error", error_inyectado, 1'b1);
        datos_in       = 4'hF;
        modo_inyeccion = 2'b10;
        pos_a          = 3'd1;
        pos_b          = 3'd2;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp%0d_palabra", c), palabra_out, 8'h54);
            chk($sformatf("bp%0d_error", c), error_inyectado, 1'b1);
            chk($sformatf("bp%0d_listo_in", c), listo_in, 1'b0);
            chk($sformatf("bp%0d_valido", c), valido_out, 1'b1);
            chk($sformatf("bp%0d_cuenta", c), palabras_enviadas, 16'd9);
        end
        listo_out      = 1'b1;
        modo_inyeccion = 2'b00;
        datos_in       = 4'hF;
        step();
        chk("b2b0_palabra", palabra_out, 8'hFF);
        chk("b2b0_error", error_inyectado, 1'b0);
        chk("b2b0_cuenta", palabras_enviadas, 16'd10);
        datos_in = 4'h0;
        step();
        chk("b2b1_palabra", palabra_out, 8'h00);
        chk("b2b1_cuenta", palabras_enviadas, 16'd11);
        datos_in = 4'hB;
        step();
        chk("b2b2_palabra", palabra_out, 8'h55);
        chk("b2b2_cuenta", palabras_enviadas, 16'd12);

        repeat (16'hFFFF - 12) @(posedge clk);
        #1;
        chk("wrap_tope", palabras_enviadas, 16'hFFFF);
        step();
        chk("wrap_cero", palabras_enviadas, 16'h0000);
        chk("wrap_valido", valido_out, 1'b1);

        listo_out = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valido", valido_out, 1'b0);
        chk("rst_async_palabra", palabra_out, 8'h00);
        chk("rst_async_cuenta", palabras_enviadas, 16'h0000);
        chk("rst_async_error", error_inyectado, 1'b0);
        chk("rst_async_listo_in", listo_in, 1'b1);
        #1;
        rst            = 1'b0;
        datos_in       = 4'hB;
        modo_inyeccion = 2'b00;
        valido_in      = 1'b1;
        step();
        chk("post_rst_palabra", palabra_out, 8'h55);
        chk("post_rst_valido", valido_out, 1'b1);
        chk("post_rst_cuenta", palabras_enviadas, 16'h0000);
        listo_out = 1'b1;
        valido_in = 1'b0;
        step();
        chk("post_rst_entrega", palabras_enviadas, 16'd1);
        chk("post_rst_vacio", valido_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/module_codificador_hamming.md
MODULE_CODIFICADOR_HAMMING -- requirements
Module: module_codificador_hamming

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset: clk input 1 is the single clock (rising edge); rst input 1 is the asynchronous active-high reset.
REQ-002 The module SHALL have input datos_in of width 4: data nibble; datos_in[0]=d1, [1]=d2, [2]=d3, [3]=d4.
REQ-003 The module SHALL have input valido_in of width 1: the producer has a nibble on datos_in.
REQ-004 The module SHALL have output listo_in of width 1: the encoder can accept a nibble this cycle.
REQ-005 The module SHALL have input modo_inyeccion of width 2: 00 none, 01 single-bit flip, 10 double-bit flip, 11 treated as 00.
REQ-006 The module SHALL have inputs pos_a and pos_b, each of width 3: bit positions 0..7 to flip in the codeword.
REQ-007 The module SHALL have output palabra_out of width 8: codeword [p1,p2,d1,p3,d2,d3,d4,p0], with bit0=p1 and bit7=p0.
REQ-008 The module SHALL have output valido_out of width 1: palabra_out holds a codeword.
REQ-009 The module SHALL have input listo_out of width 1: the consumer accepts palabra_out this cycle.
REQ-010 The module SHALL have output palabras_enviadas of width 16: count of codewords delivered.
REQ-011 The module SHALL have output error_inyectado of width 1: the current palabra_out carries an injected error.

Function
REQ-012 Encoding SHALL be p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4, and p0=XOR of codeword bits 0..6, giving even overall parity.
REQ-013 Injection SHALL be applied after encoding. Mode 01 flips bit pos_a. Mode 10 flips pos_a and pos_b. Mode 10 with pos_a==pos_b SHALL flip that single bit once only.
REQ-014 modo_inyeccion, pos_a and pos_b SHALL be sampled only on the accept cycle; later changes SHALL NOT affect a held word.
REQ-015 An input transfer SHALL occur when valido_in && listo_in at a rising clk edge.
REQ-016 An output transfer SHALL occur when valido_out && listo_out at a rising clk edge.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N drives palabra_out and valido_out from edge N onward.
REQ-018 The FSM SHALL have two states, VACIO and LLENO.
REQ-019 In VACIO, listo_in SHALL be 1 and valido_out SHALL be 0; an input transfer moves the FSM to LLENO.
REQ-020 In LLENO, valido_out SHALL be 1 and listo_in SHALL equal listo_out.
REQ-021 In LLENO with an output transfer and a simultaneous input transfer, the FSM SHALL stay in LLENO and load the new word; full throughput is one word per cycle.
REQ-022 In LLENO with an output transfer and no input transfer, the FSM SHALL return to VACIO.
REQ-023 In LLENO without an output transfer, palabra_out and error_inyectado SHALL be held stable.
REQ-024 listo_in SHALL be combinational from state and listo_out only; valido_out, palabra_out and error_inyectado SHALL be registered.
REQ-025 palabras_enviadas SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 16'h0000 without saturation.
REQ-026 error_inyectado SHALL be 1 exactly when the latched mode is 01 or 10.
REQ-027 valido_in while listo_in=0 SHALL be ignored, with no state change.

Reset
REQ-028 While rst=1, regardless of clk: state=VACIO, valido_out=0, palabra_out=8'h00, error_inyectado=0, palabras_enviadas=16'h0000.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; no partial word or count SHALL survive.
REQ-030 The first transfer after deassertion SHALL be possible at the first rising edge with rst=0.

Structure
REQ-031 A shared package (pkg_hamming) SHALL hold: the bit-position constants for p1,p2,d1,p3,d2,d3,d4,p0; the injection-mode enum; and the FSM state enum. The existing error detector SHALL reuse the same constants.
REQ-032 The purely combinational encoder SHALL be a sub-module, module_hamming_encode (4-bit in, 8-bit out). Handshake, injection and counter logic SHALL live in the top module.

Verification
REQ-033 Encoding SHALL be checked with mode 00 and listo_out=1: datos_in=4'hB -> palabra_out=8'h55; 4'h0 -> 8'h00; 4'hF -> 8'hFF; error_inyectado=0.
REQ-034 Single-bit injection SHALL be checked: datos_in=4'hB, mode 01, pos_a=2 -> palabra_out=8'h51, error_inyectado=1. Looped into the detector, this SHALL give non-zero syndrome and paridad_global=1.
REQ-035 Double-bit injection SHALL be checked: datos_in=4'h0, mode 10, pos_a=0, pos_b=7 -> palabra_out=8'h81. Also mode 10 with pos_a=pos_b=3 -> 8'h08.
REQ-036 Backpressure SHALL be checked: hold listo_out=0 for 5 cycles after an accept -> palabra_out stable, listo_in=0, and a second valido_in is not consumed; then listo_out=1 with valido_in=1 -> back-to-back transfers, count +1 per cycle.
REQ-037 Counter wrap SHALL be checked: force 16'hFFFF transfers -> the next output transfer gives palabras_enviadas=16'h0000.
REQ-038 Reset mid-operation SHALL be checked: assert rst asynchronously while in LLENO -> valido_out=0, palabra_out=8'h00 and count=0 before the next clk edge.
